// File: rtl/onchip_mem_stream_reader.sv
// onchip_mem_stream_reader
//   Avalon-MM read master that drains a contiguous word range out of a
//   single-port on-chip memory (fixed one-cycle read latency, no waitrequest,
//   no readdatavalid) and presents it as a ready/valid stream through a small
//   credit-controlled, show-ahead output FIFO.
//
// Optional build macro: ONCHIP_READER_FRAMING_EN
//   When defined, adds st_sop / st_eop (qualified by st_valid) marking the
//   first and last word of each transfer.
//
// Ports
//   clk, reset            single clock; synchronous active-high reset
//   start                 one-cycle transfer request, honoured only when idle
//   base_addr, length     first word address and word count (0..2^ADDR_W)
//   busy, done            transfer in progress / one-cycle completion pulse
//   m_address ... m_writedata, m_readdata   memory s1 slave port
//   st_data, st_valid, st_ready             output stream
//   st_sop, st_eop        (framing build only) packet delimiters
module onchip_mem_stream_reader #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] m_address,
   output logic              m_chipselect,
   output logic              m_write,
   output logic [3:0]        m_byteenable,
   output logic              m_clken,
   output logic [DATA_W-1:0] m_writedata,
   input  logic [DATA_W-1:0] m_readdata,
   output logic [DATA_W-1:0] st_data,
   output logic              st_valid,
   input  logic              st_ready
`ifdef ONCHIP_READER_FRAMING_EN
   ,
   output logic              st_sop,
   output logic              st_eop
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   issue_cnt;
   logic              inflight;       // read issued last cycle; data on m_readdata now
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              fifo_empty, credit, issue, pop, accept, done_next;

   // Show-ahead output: when the FIFO is empty the word arriving from memory
   // this cycle is presented directly, giving first data two cycles after
   // start. It is also written into the FIFO, so if it is not taken now it
   // reappears unchanged from storage next cycle.
   always_comb begin
      fifo_empty = (count == '0);
      st_valid   = !fifo_empty || inflight;
      st_data    = !fifo_empty ? fifo_data[rd_ptr] : (inflight ? m_readdata : '0);
      pop        = st_valid && st_ready;
      // count + inflight is every word already committed to the FIFO
      credit     = (count + CNT_W'(inflight)) < DEPTH_C;
   end

   always_comb begin
      state_next = state;
      issue      = 1'b0;
      accept     = 1'b0;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (length != '0) begin
                  accept     = 1'b1;
                  state_next = ISSUE;
               end else begin
                  done_next  = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (credit) begin
               issue = 1'b1;
               if (issue_cnt == (ADDR_W+1)'(1)) state_next = DRAIN;
            end
         end
         DRAIN: begin
            // Leave when this cycle empties everything, so done and the fall
            // of busy land together in the cycle after the last handshake.
            if ((count + CNT_W'(inflight)) == CNT_W'(pop)) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         done      <= 1'b0;
         inflight  <= 1'b0;
         addr      <= '0;
         issue_cnt <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
      end else begin
         state    <= state_next;
         done     <= done_next;
         inflight <= issue;
         if (accept) begin
            addr      <= base_addr;
            issue_cnt <= length;
         end else if (issue) begin
            addr      <= addr + 1'b1;
            issue_cnt <= issue_cnt - 1'b1;
         end
         if (inflight) wr_ptr <= wr_ptr + 1'b1;
         if (pop)      rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(inflight) - CNT_W'(pop);
      end
   end

   // ---- capture stage: memory data lands in the FIFO one cycle after issue
   always_ff @(posedge clk) begin
      if (inflight) fifo_data[wr_ptr] <= m_readdata;
   end

`ifdef ONCHIP_READER_FRAMING_EN
   logic first_pend, sop_p1, eop_p1;
   logic fifo_sop [FIFO_DEPTH];
   logic fifo_eop [FIFO_DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         first_pend <= 1'b0;
         sop_p1     <= 1'b0;
         eop_p1     <= 1'b0;
      end else begin
         if (accept)     first_pend <= 1'b1;
         else if (issue) first_pend <= 1'b0;
         sop_p1 <= issue && first_pend;
         eop_p1 <= issue && (issue_cnt == (ADDR_W+1)'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (inflight) begin
         fifo_sop[wr_ptr] <= sop_p1;
         fifo_eop[wr_ptr] <= eop_p1;
      end
   end

   assign st_sop = st_valid && (fifo_empty ? sop_p1 : fifo_sop[rd_ptr]);
   assign st_eop = st_valid && (fifo_empty ? eop_p1 : fifo_eop[rd_ptr]);
`endif

   assign busy         = (state != IDLE);
   assign m_chipselect = issue;
   assign m_address    = addr;
   assign m_write      = 1'b0;
   assign m_byteenable = 4'hF;
   assign m_clken      = 1'b1;
   assign m_writedata  = '0;

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Testbench for onchip_mem_stream_reader: memory model, scoreboard of expected
// stream words and read addresses, and a monitor that checks every handshake.
module tb_onchip_mem_stream_reader;
   localparam int ADDR_W = 12, DATA_W = 32, FIFO_DEPTH = 4;

   logic              clk = 1'b0, reset = 1'b1, start = 1'b0, st_ready = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   length = '0;
   logic              busy, done, m_chipselect, m_write, m_clken, st_valid;
   logic [3:0]        m_byteenable;
   logic [ADDR_W-1:0] m_address;
   logic [DATA_W-1:0] m_writedata, st_data;
   logic [DATA_W-1:0] m_readdata = '0;
`ifdef ONCHIP_READER_FRAMING_EN
   logic st_sop, st_eop;
`endif

   int checks = 0, errors = 0, issued = 0, popped = 0;
   logic [31:0] mem [4096];

   typedef struct packed {logic [31:0] d; logic sop; logic eop;} exp_t;
   exp_t        exp_q[$];
   logic [11:0] addr_q[$];
   exp_t        mon_e;
   logic        hold_pend = 1'b0;
   logic [31:0] hold_data = '0;

   onchip_mem_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy), .done(done), .m_address(m_address), .m_chipselect(m_chipselect),
      .m_write(m_write), .m_byteenable(m_byteenable), .m_clken(m_clken),
      .m_writedata(m_writedata), .m_readdata(m_readdata),
      .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready)
`ifdef ONCHIP_READER_FRAMING_EN
      , .st_sop(st_sop), .st_eop(st_eop)
`endif
   );

   always #5 clk = ~clk;

   // One-cycle-latency memory
   always @(posedge clk) if (m_chipselect) m_readdata <= mem[m_address];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
      end
   endtask

   // Monitor: compares reads and stream words against the scoreboard
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         addr_q.delete();
         issued    = 0;
         popped    = 0;
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            chk("st_valid_held", 32'(st_valid), 32'd1);
            chk("st_data_stable", st_data, hold_data);
         end
         if (m_chipselect) begin
            chk("credit_on_issue", 32'((issued - popped) < FIFO_DEPTH), 32'd1);
            if (addr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_read actual_addr=0x%0h required=none", m_address);
            end else begin
               chk("m_address", 32'(m_address), 32'(addr_q.pop_front()));
            end
            issued++;
         end
         if (st_valid && st_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_word actual=0x%0h required=none", st_data);
            end else begin
               mon_e = exp_q.pop_front();
               chk("st_data", st_data, mon_e.d);
`ifdef ONCHIP_READER_FRAMING_EN
               chk("st_sop", 32'(st_sop), 32'(mon_e.sop));
               chk("st_eop", 32'(st_eop), 32'(mon_e.eop));
`endif
            end
            popped++;
         end
         if (m_chipselect || st_valid)
            chk("occupancy_bound", 32'((issued - popped) <= FIFO_DEPTH), 32'd1);
         hold_pend = st_valid && !st_ready;
         hold_data = st_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: transfer n from b yields mem[(b+i) mod 4096], i = 0..n-1
   task automatic start_xfer(input logic [11:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         logic [11:0] a;
         a     = b + 12'(i);
         e.d   = mem[a];
         e.sop = (i == 0);
         e.eop = (i == n - 1);
         exp_q.push_back(e);
         addr_q.push_back(a);
      end
      base_addr = b;
      length    = 13'(n);
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   // Called in cycle T+1. mode: 0 ready high, 1 ready 1-0-0-1, 2 random.
   task automatic wait_done(input int n, input int mode, input bit timing, input bit inj);
      int c;
      bit seen;
      c    = 1;
      seen = 1'b0;
      while (c <= 40 * n + 60 && !seen) begin
         case (mode)
            0:       st_ready = 1'b1;
            1:       st_ready = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
            default: st_ready = 1'($urandom_range(0, 1));
         endcase
         if (inj) begin
            if (c == 3) begin
               base_addr = 12'h300; length = 13'd5; start = 1'b1;
            end else begin
               start = 1'b0;
            end
         end
         if (c == 1) begin
            chk("busy_T1", 32'(busy), 32'd1);
            chk("cs_T1", 32'(m_chipselect), 32'd1);
         end
         if (timing && c == 2) chk("st_valid_T2", 32'(st_valid), 32'd1);
         if (done) begin
            seen = 1'b1;
            chk("busy_low_at_done", 32'(busy), 32'd0);
            if (timing) chk("done_cycle", 32'(c), 32'(n + 2));
         end else begin
            tick();
            c++;
         end
      end
      start = 1'b0;
      if (!seen) begin
         checks++; errors++;
         $display("FAIL done_timeout actual=no_done required=done_within_%0d", 40 * n + 60);
      end else begin
         chk("all_words_delivered", 32'(exp_q.size()), 32'd0);
      end
      st_ready = 1'b1;
      tick();
      chk("done_single_pulse", 32'(done), 32'd0);
   endtask

   initial begin
      int guard;
      for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 + 32'(i);

      repeat (3) tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_st_valid", 32'(st_valid), 32'd0);
      chk("rst_cs", 32'(m_chipselect), 32'd0);
      chk("rst_m_address", 32'(m_address), 32'd0);
      chk("rst_st_data", st_data, 32'd0);
      chk("m_write", 32'(m_write), 32'd0);
      chk("m_byteenable", 32'(m_byteenable), 32'hF);
      chk("m_clken", 32'(m_clken), 32'd1);
      chk("m_writedata", m_writedata, 32'd0);
      reset    = 1'b0;
      st_ready = 1'b1;
      tick();

      // Basic run, then wrap past the top of memory
      st_ready = 1'b1; start_xfer(12'h010, 8);  wait_done(8, 0, 1, 0);
      st_ready = 1'b1; start_xfer(12'hFFE, 4);  wait_done(4, 0, 1, 0);
      // Backpressure pattern
      st_ready = 1'b1; start_xfer(12'h100, 16); wait_done(16, 1, 0, 0);

      // Zero-length request
      base_addr = 12'h020; length = '0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("len0_done", 32'(done), 32'd1);
      chk("len0_busy", 32'(busy), 32'd0);
      chk("len0_cs", 32'(m_chipselect), 32'd0);
      tick();
      chk("len0_done_once", 32'(done), 32'd0);
      chk("len0_busy_after", 32'(busy), 32'd0);

      // Start during an active transfer is ignored
      st_ready = 1'b1; start_xfer(12'h040, 8); wait_done(8, 0, 1, 1);
      repeat (4) tick();
      chk("ignored_start_idle", 32'(st_valid), 32'd0);

      // Reset mid-transfer after three words
      st_ready = 1'b1;
      start_xfer(12'h200, 8);
      guard = 0;
      while (popped < 3 && guard < 50) begin tick(); guard++; end
      chk("three_words_before_reset", 32'(popped >= 3), 32'd1);
      st_ready = 1'b0;
      reset    = 1'b1;
      tick();
      reset    = 1'b0;
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_st_valid", 32'(st_valid), 32'd0);
      chk("post_rst_cs", 32'(m_chipselect), 32'd0);
      chk("post_rst_done", 32'(done), 32'd0);
      st_ready = 1'b1; start_xfer(12'h0A0, 2); wait_done(2, 0, 1, 0);

      // Single-word and three-word transfers (framing checked when built in)
      st_ready = 1'b1; start_xfer(12'h007, 1); wait_done(1, 0, 1, 0);
      st_ready = 1'b1; start_xfer(12'h008, 3); wait_done(3, 0, 1, 0);

      // Randomized transfers over random memory contents
      for (int i = 0; i < 4096; i++) mem[i] = $urandom;
      for (int t = 0; t < 8; t++) begin
         logic [11:0] b;
         int n, mode;
         b    = 12'($urandom);
         n    = $urandom_range(1, 40);
         mode = (t % 3 == 0) ? 1 : 2;
         st_ready = 1'($urandom_range(0, 1));
         start_xfer(b, n);
         wait_done(n, mode, 0, 0);
      end

      repeat (5) tick();
      chk("final_idle_valid", 32'(st_valid), 32'd0);
      chk("final_idle_busy", 32'(busy), 32'd0);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
